// File: rtl/control_multi_if.sv
// control_multi_if: opcode/handshake inputs and datapath control lines of the multi-cycle MIPS controller
interface control_multi_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_op
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_op
    );
endinterface

// File: rtl/control_multi.sv
// control_multi: multi-cycle MIPS control FSM driving a shared-memory datapath.
// Define CTRL_ILLEGAL_TRAP_EN to park in a sticky TRAP state on undefined opcodes (else they retire as NOPs).
module control_multi #(
    parameter logic [5:0] R_FORMAT = 6'd0,
    parameter logic [5:0] LW       = 6'd35,
    parameter logic [5:0] SW       = 6'd43,
    parameter logic [5:0] BEQ      = 6'd4,
    parameter logic [5:0] BNE      = 6'd5,
    parameter logic [5:0] ADDIU    = 6'd9,
    parameter logic [5:0] J        = 6'd2,
    parameter int         ST_W     = 4
) (
    input logic            clk,
    input logic            rst_n,
    control_multi_if.master bus
);
    typedef enum logic [ST_W-1:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;
    state_t state, nxt;
    logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic is_mem, is_br, legal;
    assign is_mem = bus.opcode == LW || bus.opcode == SW;
    assign is_br  = bus.opcode == BEQ || bus.opcode == BNE;
    assign legal  = is_mem || is_br || bus.opcode == R_FORMAT || bus.opcode == J || bus.opcode == ADDIU;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else        state <= nxt;
    always_comb begin
        nxt           = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                nxt       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                nxt = is_mem                 ? MEM_ADDR  :
                      bus.opcode == R_FORMAT ? R_EXEC    :
                      is_br                  ? BRANCH    :
                      bus.opcode == J        ? JUMP      :
                      bus.opcode == ADDIU    ? ADDI_EXEC :
`ifdef CTRL_ILLEGAL_TRAP_EN
                                               TRAP;
`else
                                               FETCH;
                instr_done = !legal;
`endif
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = bus.opcode == LW ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                nxt      = bus.mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = bus.mem_ready;
                nxt        = bus.mem_ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = R_WB;
            end
            R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = bus.opcode == BNE;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal_op = 1'b1;
                nxt        = TRAP;
            end
`endif
            default: nxt = FETCH;
        endcase
    end
    // Reset must silence every strobe immediately, even though FETCH itself asserts a read.
    assign bus.pc_write      = rst_n & pc_write;
    assign bus.pc_write_cond = rst_n & pc_write_cond;
    assign bus.branch_ne     = rst_n & branch_ne;
    assign bus.i_or_d        = rst_n & i_or_d;
    assign bus.mem_read      = rst_n & mem_read;
    assign bus.mem_write     = rst_n & mem_write;
    assign bus.ir_write      = rst_n & ir_write;
    assign bus.mem_to_reg    = rst_n & mem_to_reg;
    assign bus.reg_dst       = rst_n & reg_dst;
    assign bus.reg_write     = rst_n & reg_write;
    assign bus.alu_src_a     = rst_n & alu_src_a;
    assign bus.alu_src_b     = rst_n ? alu_src_b : 2'b00;
    assign bus.alu_op        = rst_n ? alu_op : 2'b00;
    assign bus.pc_source     = rst_n ? pc_source : 2'b00;
    assign bus.instr_done    = rst_n & instr_done;
    assign bus.illegal_op    = rst_n & illegal_op;
endmodule
